// File: rtl/sample.sv
// sample: per-bit synchronizer and debouncer for an asynchronous level bus.
// Each bit of A passes through two flops, then must disagree with B for
// STABLE_CYCLES consecutive clocks before B adopts the new value.
module sample #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4   // legal range 1..255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B
);

  // Counter must hold STABLE_CYCLES-1; one bit minimum when STABLE_CYCLES is 1.
  localparam int               CNT_W   = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [WIDTH-1:0]            s1_q, s2_q;
  logic [WIDTH-1:0]            b_q, b_d;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q, cnt_d;

  // Two-flop synchronizer; nothing downstream sees A before s2_q.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would collapse s1 and s2 into one stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= A;
      s2_q <= s1_q;
    end
  end

  // Per-bit stability filter: count disagreement, load B on the last count,
  // clear the count whenever the synchronized bit agrees with B again.
  // NOTE: both outputs get a default before the loop so no path leaves them
  // unassigned, which would otherwise infer latches.
  always_comb begin
    b_d   = b_q;
    cnt_d = cnt_q;
    for (int i = 0; i < WIDTH; i++) begin
      if (s2_q[i] == b_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        b_d[i]   = s2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  // Filter state registers; reset discards any count in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      b_q   <= b_d;
      cnt_q <= cnt_d;
    end
  end

  // B comes straight from flops: no combinational path from A.
  assign B = b_q;

endmodule

// File: tb/tb_sample.sv
// tb_sample: directed checks of the sample debouncer at STABLE_CYCLES=4
// (main instance) and STABLE_CYCLES=1 (second instance).
module tb_sample;

  logic       clk;
  logic       rst_n;
  logic [3:0] a, b;     // STABLE_CYCLES = 4 instance
  logic [3:0] a1, b1;   // STABLE_CYCLES = 1 instance

  int checks   = 0;
  int failures = 0;

  sample #(.WIDTH(4), .STABLE_CYCLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a),
    .B     (b)
  );

  sample #(.WIDTH(4), .STABLE_CYCLES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (a1),
    .B     (b1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling outputs.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset held with A=1010 keeps B at 0; after release B=1010 on 6th edge only.
  task automatic test_reset();
    a     = 4'b1010;
    a1    = 4'b0000;
    rst_n = 1'b0;
    #2;
    checks++;
    if (b !== 4'b0000) begin
      $display("FAIL reset_async b=%b expected=%b", b, 4'b0000);
      failures++;
    end
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (b !== 4'b0000) begin
        $display("FAIL reset_hold edge%0d b=%b expected=%b", e, b, 4'b0000);
        failures++;
      end
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (b !== ((e < 6) ? 4'b0000 : 4'b1010)) begin
        $display("FAIL reset_release edge%0d b=%b expected=%b", e, b,
                 (e < 6) ? 4'b0000 : 4'b1010);
        failures++;
      end
    end
  endtask

  // Two bits change together and update on the same edge; others never glitch.
  task automatic test_multi_bit();
    a = 4'b1100;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (b !== ((e < 6) ? 4'b1010 : 4'b1100)) begin
        $display("FAIL multi_bit edge%0d b=%b expected=%b", e, b,
                 (e < 6) ? 4'b1010 : 4'b1100);
        failures++;
      end
      checks++;
      if (b[3] !== 1'b1 || b[0] !== 1'b0) begin
        $display("FAIL multi_bit_steady edge%0d b3=%b b0=%b expected b3=1 b0=0",
                 e, b[3], b[0]);
        failures++;
      end
    end
  endtask

  // A two-cycle dip shorter than the filter window is ignored and counters clear.
  task automatic test_glitch();
    a = 4'b0000;
    step();
    step();
    a = 4'b1100;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if (b !== 4'b1100) begin
        $display("FAIL glitch edge%0d b=%b expected=%b", e, b, 4'b1100);
        failures++;
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dut.cnt_q[i] !== 2'd0) begin
        $display("FAIL glitch_cnt bit%0d cnt=%0d expected=0", i, dut.cnt_q[i]);
        failures++;
      end
    end
  endtask

  // Full fall to 0000, then reset mid-count toward 1111 restarts from B=0.
  task automatic test_fall_then_reset();
    a = 4'b0000;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (b !== ((e < 6) ? 4'b1100 : 4'b0000)) begin
        $display("FAIL fall edge%0d b=%b expected=%b", e, b,
                 (e < 6) ? 4'b1100 : 4'b0000);
        failures++;
      end
    end
    a = 4'b1111;
    step();
    step();
    step();
    step();   // s2 = 1111, counters at 2
    checks++;
    if (dut.cnt_q[0] !== 2'd2) begin
      $display("FAIL midcount_cnt cnt0=%0d expected=2", dut.cnt_q[0]);
      failures++;
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b !== 4'b0000 || dut.cnt_q[0] !== 2'd0) begin
      $display("FAIL midcount_reset b=%b cnt0=%0d expected b=0000 cnt0=0",
               b, dut.cnt_q[0]);
      failures++;
    end
    step();
    rst_n = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      step();
      checks++;
      if (b !== ((e < 6) ? 4'b0000 : 4'b1111)) begin
        $display("FAIL restart edge%0d b=%b expected=%b", e, b,
                 (e < 6) ? 4'b0000 : 4'b1111);
        failures++;
      end
    end
  endtask

  // Reset clears a nonzero B between clock edges.
  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (b !== 4'b0000) begin
      $display("FAIL async_reset b=%b expected=%b", b, 4'b0000);
      failures++;
    end
    step();
    rst_n = 1'b1;
    a     = 4'b0000;
  endtask

  // STABLE_CYCLES=1: B follows s2 one register later, 3 edges total.
  task automatic test_sc1();
    step();
    step();
    step();
    checks++;
    if (b1 !== 4'b0000) begin
      $display("FAIL sc1_idle b1=%b expected=%b", b1, 4'b0000);
      failures++;
    end
    a1 = 4'b1010;
    for (int e = 1; e <= 4; e++) begin
      step();
      checks++;
      if (b1 !== ((e < 3) ? 4'b0000 : 4'b1010)) begin
        $display("FAIL sc1 edge%0d b1=%b expected=%b", e, b1,
                 (e < 3) ? 4'b0000 : 4'b1010);
        failures++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_multi_bit();
    test_glitch();
    test_fall_then_reset();
    test_async_reset();
    test_sc1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sample.md
SAMPLE -- requirements
Module: sample

Interface
REQ-001 Parameter WIDTH, default 4: width of input A and output B.
REQ-002 Parameter STABLE_CYCLES, default 4: clock cycles a synchronized input bit must differ from B before B takes the new value; legal range 1..255.
REQ-003 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous and active-low.
REQ-005 Port A, input, WIDTH: asynchronous multi-bit level input to be sampled and filtered.
REQ-006 Port B, output, WIDTH: registered, synchronized and debounced copy of A.
REQ-007 The block SHALL have no ports other than clk, rst_n, A and B.

Function
REQ-008 A SHALL pass through a 2-flop synchronizer per bit (s1, then s2) before any other logic uses it.
REQ-009 Each bit i SHALL have its own stability counter cnt[i] of width max(1, ceil(log2(STABLE_CYCLES))).
REQ-010 On each rising edge, if s2[i] == B[i], cnt[i] SHALL clear to 0 and B[i] SHALL hold.
REQ-011 On each rising edge, if s2[i] != B[i] and cnt[i] == STABLE_CYCLES-1, B[i] SHALL load s2[i] and cnt[i] SHALL clear to 0.
REQ-012 On each rising edge, if s2[i] != B[i] and cnt[i] < STABLE_CYCLES-1, cnt[i] SHALL increment by 1 and B[i] SHALL hold.
REQ-013 Latency: A settled before rising edge N SHALL appear on B after rising edge N+1+STABLE_CYCLES (STABLE_CYCLES=4: 6th edge counting edge N as the 1st).
REQ-014 A pulse or glitch on s2[i] lasting fewer than STABLE_CYCLES cycles SHALL NOT change B[i]; its return to B[i]'s value SHALL clear cnt[i].
REQ-015 Bits SHALL be filtered independently; bits that change together SHALL update B on the same edge; unchanged bits SHALL never glitch.
REQ-016 STABLE_CYCLES=1 SHALL give B[i] = s2[i] delayed by one register (total latency 3 edges).
REQ-017 cnt[i] SHALL never exceed STABLE_CYCLES-1 and SHALL never wrap.
REQ-018 B SHALL be driven directly from flops with no combinational path from A.

Reset
REQ-019 While rst_n is low, s1, s2, every cnt[i] and B SHALL be 0, asynchronously and independent of clk.
REQ-020 Reset asserted mid-count SHALL discard the count; after release, filtering SHALL restart from B=0 with full latency per REQ-013.
REQ-021 The first rising edge after rst_n rises SHALL be treated as a normal edge; reset release is assumed synchronous to clk.

Verification
REQ-022 Hold rst_n=0 with A=4'b1010 -> B=4'b0000 throughout; after release B=4'b1010 on the 6th edge, unchanged on the 5th.
REQ-023 From B=4'b1010, A=4'b1100 -> B stays 4'b1010 for 5 edges, becomes 4'b1100 on the 6th; bit 3 holds 1 and bit 0 holds 0 at every edge.
REQ-024 From B=4'b1100, A=4'b0000 held 2 cycles then back to 4'b1100 -> B never changes, all counters return to 0.
REQ-025 From B=4'b1100, A=4'b0000 held -> B=4'b0000 on the 6th edge; then rst_n pulsed low mid-count with A=4'b1111 -> B=0 immediately, B=4'b1111 on the 6th edge after release.
REQ-026 STABLE_CYCLES=1, A stepped 4'b0000->4'b1010 -> B=4'b1010 on the 3rd edge.
